// File: rtl/tm_pkg.sv
// -----------------------------------------------------------------------------
// tm_pkg
// Shared types for the Turing machine input side.
//   DEFAULT_SYM_W  : default symbol width used by the tape feeder and its buffer
//   feeder_state_t : sequencer states of the tape feeder
//   symbol_t       : one tape symbol at the default width
// -----------------------------------------------------------------------------
package tm_pkg;

   localparam int DEFAULT_SYM_W = 4;

   typedef enum logic [2:0] {
      IDLE,
      SEND,
      GAP,
      FINISH,
      WAIT
   } feeder_state_t;

   typedef logic [DEFAULT_SYM_W-1:0] symbol_t;

endpackage

// File: rtl/tape_buffer.sv
// -----------------------------------------------------------------------------
// tape_buffer
// DEPTH x SYM_W register file holding the tape before it is sent.
// Ports:
//   clock, reset : system clock, asynchronous active-high clear
//   wrEn_i       : write strobe
//   wrIdx_i      : write slot
//   wrData_i     : symbol to store
//   rdIdx_i      : read slot
//   rdData_o     : combinational read of slot rdIdx_i
// -----------------------------------------------------------------------------
module tape_buffer #(
   parameter int DEPTH = 8,
   parameter int SYM_W = 4,
   parameter int IW    = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             wrEn_i,
   input  logic [IW-1:0]    wrIdx_i,
   input  logic [SYM_W-1:0] wrData_i,
   input  logic [IW-1:0]    rdIdx_i,
   output logic [SYM_W-1:0] rdData_o
);

   logic [SYM_W-1:0] mem_q [DEPTH];

   // Storage: the owner only raises wrEn_i for a slot below DEPTH, so no
   // range guard is needed here. Reset wipes every slot.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         for (int i = 0; i < DEPTH; i++) begin
            mem_q[i] <= '0;
         end
      end else if (wrEn_i) begin
         mem_q[wrIdx_i] <= wrData_i;
      end
   end

   assign rdData_o = mem_q[rdIdx_i];

endmodule

// File: rtl/tape_feeder.sv
// -----------------------------------------------------------------------------
// tape_feeder
// Buffers up to DEPTH symbols from the board front end, then plays them to the
// Turing machine as input_data + one-cycle Next strobes spaced GAP+1 cycles
// apart, followed by a one-cycle Done strobe. Holds off new loads until the
// machine reports compute_done.
// Ports:
//   clock, reset             : system clock, asynchronous active-high clear
//   load_valid, load_sym     : symbol offered for the buffer
//   load_ready               : buffer takes a symbol this cycle
//   start                    : begin sending the buffered tape
//   abort                    : synchronous cancel, empties the buffer
//   compute_done             : machine finished with the tape
//   input_data, Next, Done   : symbol protocol towards the machine
//   busy                     : a transmission is in progress
//   count                    : symbols currently buffered
// -----------------------------------------------------------------------------
module tape_feeder #(
   parameter  int DEPTH = 8,
   parameter  int SYM_W = tm_pkg::DEFAULT_SYM_W,
   parameter  int GAP   = 4,
   localparam int CW    = $clog2(DEPTH + 1),
   localparam int IW    = (DEPTH > 1) ? $clog2(DEPTH) : 1,
   localparam int GW    = $clog2(GAP + 1)
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             load_valid,
   input  logic [SYM_W-1:0] load_sym,
   output logic             load_ready,
   input  logic             start,
   input  logic             abort,
   input  logic             compute_done,
   output logic [SYM_W-1:0] input_data,
   output logic             Next,
   output logic             Done,
   output logic             busy,
   output logic [CW-1:0]    count
);

   tm_pkg::feeder_state_t state_q;
   logic [CW-1:0]    count_q;
   logic [CW-1:0]    rdPtr_q;
   logic [GW-1:0]    gapCnt_q;
   logic [SYM_W-1:0] data_q;
   logic             next_q;
   logic             done_q;
   logic             busy_q;

   logic             loadAccept_d;
   logic [CW-1:0]    loadCount_d;
   logic [CW-1:0]    nextPtr_d;
   logic [IW-1:0]    wrIdx_d;
   logic [IW-1:0]    rdIdx_d;
   logic [SYM_W-1:0] rdData;
   logic [SYM_W-1:0] sendData_d;

   // Load handshake and buffer addressing. The read port looks ahead to the
   // slot about to be sent, so input_data can be registered on entry to SEND.
   // When start meets a load into an empty buffer, slot 0 is being written in
   // that very cycle, so the incoming symbol is forwarded instead.
   assign load_ready   = (state_q == tm_pkg::IDLE) && (count_q < CW'(DEPTH));
   assign loadAccept_d = load_valid && load_ready && !abort;
   assign loadCount_d  = count_q + CW'(loadAccept_d);
   assign nextPtr_d    = rdPtr_q + CW'(1);
   assign wrIdx_d      = count_q[IW-1:0];
   assign rdIdx_d      = (state_q == tm_pkg::IDLE) ? '0 : nextPtr_d[IW-1:0];
   assign sendData_d   = ((state_q == tm_pkg::IDLE) && (count_q == '0)) ? load_sym : rdData;

   tape_buffer #(
      .DEPTH (DEPTH),
      .SYM_W (SYM_W),
      .IW    (IW)
   ) u_buffer (
      .clock    (clock),
      .reset    (reset),
      .wrEn_i   (loadAccept_d),
      .wrIdx_i  (wrIdx_d),
      .wrData_i (load_sym),
      .rdIdx_i  (rdIdx_d),
      .rdData_o (rdData)
   );

   // Sequencer. Next/Done are raised on the transition into SEND/FINISH and
   // dropped on the following cycle, which keeps them one cycle wide and
   // registered. abort beats start and load, and leaves input_data untouched.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state_q  <= tm_pkg::IDLE;
         count_q  <= '0;
         rdPtr_q  <= '0;
         gapCnt_q <= '0;
         data_q   <= '0;
         next_q   <= 1'b0;
         done_q   <= 1'b0;
         busy_q   <= 1'b0;
      end else if (abort) begin
         state_q <= tm_pkg::IDLE;
         count_q <= '0;
         next_q  <= 1'b0;
         done_q  <= 1'b0;
         busy_q  <= 1'b0;
      end else begin
         next_q <= 1'b0;
         done_q <= 1'b0;
         case (state_q)
            tm_pkg::IDLE: begin
               count_q <= loadCount_d;
               if (start) begin
                  busy_q  <= 1'b1;
                  rdPtr_q <= '0;
                  if (loadCount_d != '0) begin
                     state_q <= tm_pkg::SEND;
                     next_q  <= 1'b1;
                     data_q  <= sendData_d;
                  end else begin
                     state_q <= tm_pkg::FINISH;
                     done_q  <= 1'b1;
                  end
               end
            end
            tm_pkg::SEND: begin
               gapCnt_q <= GW'(GAP - 1);
               state_q  <= tm_pkg::GAP;
            end
            tm_pkg::GAP: begin
               if (gapCnt_q != '0) begin
                  gapCnt_q <= gapCnt_q - GW'(1);
               end else begin
                  rdPtr_q <= nextPtr_d;
                  if (nextPtr_d < count_q) begin
                     state_q <= tm_pkg::SEND;
                     next_q  <= 1'b1;
                     data_q  <= rdData;
                  end else begin
                     state_q <= tm_pkg::FINISH;
                     done_q  <= 1'b1;
                  end
               end
            end
            tm_pkg::FINISH: begin
               state_q <= tm_pkg::WAIT;
            end
            tm_pkg::WAIT: begin
               if (compute_done) begin
                  state_q <= tm_pkg::IDLE;
                  busy_q  <= 1'b0;
                  count_q <= '0;
               end
            end
            default: begin
               state_q <= tm_pkg::IDLE;
            end
         endcase
      end
   end

   assign input_data = data_q;
   assign Next       = next_q;
   assign Done       = done_q;
   assign busy       = busy_q;
   assign count      = count_q;

endmodule

// File: doc/tape_feeder.md
# tape_feeder

Input-side sequencer for the Turing machine datapath. It buffers a tape of up to DEPTH symbols loaded from the switch/button front end, then drives the machine's symbol-input protocol. The protocol is input_data plus a one-cycle Next strobe per symbol, followed by a one-cycle Done strobe. The block then holds off new loads until the machine reports Compute_done. It sits between the board input conditioning and the TuringMachine instance, replacing direct sw/btn wiring.

## Interface
- DEPTH, 8: tape buffer capacity in symbols (≥1).
- SYM_W, 4: symbol width in bits.
- GAP, 4: idle cycles between consecutive Next strobes (≥1).

- clock  in  1  system clock (clk100 domain); all state on rising edge.
- reset  in  1  asynchronous, active-high; clears all state.
- load_valid  in  1  offer load_sym for the buffer.
- load_sym  in  SYM_W  symbol to append.
- load_ready  out  1  buffer accepts a symbol this cycle.
- start  in  1  begin transmitting the buffered tape.
- abort  in  1  synchronous cancel; returns to IDLE and empties the buffer.
- compute_done  in  1  Compute_done from the TuringMachine.
- input_data  out  SYM_W  symbol presented to the machine.
- Next  out  1  one-cycle strobe: input_data is valid.
- Done  out  1  one-cycle strobe: end of tape.
- busy  out  1  a transmission is in progress (state ≠ IDLE).
- count  out  $clog2(DEPTH+1)  symbols currently buffered.

## Operation
- States: IDLE, SEND, GAP, FINISH, WAIT.
- IDLE:
  - load_ready = (count < DEPTH).
  - A load_valid & load_ready cycle writes buf[count] and increments count.
  - load_valid when full is ignored; count saturates at DEPTH.
- IDLE + start:
  - Go to SEND with rd_ptr = 0 if the post-load count > 0.
  - Otherwise go to FINISH; an empty tape sends Done only.
  - A load accepted in the same cycle as start is included in the tape.
- SEND (1 cycle):
  - Next = 1; input_data = buf[rd_ptr].
  - Go to GAP with the gap counter = GAP−1.
- GAP:
  - Count down.
  - At 0: rd_ptr++; go to SEND if more symbols remain, else FINISH.
- FINISH (1 cycle): Done = 1; go to WAIT.
- WAIT: when compute_done = 1, go to IDLE and set count = 0 (buffer consumed).
- input_data holds its last driven value outside SEND; it changes only on entry to SEND.
- load_ready = 0 whenever busy. start while busy is ignored.
- abort outside IDLE:
  - Next cycle: IDLE, count = 0, Next/Done = 0.
  - If abort arrives in FINISH, Done is not repeated.
  - abort in IDLE clears the buffer.
  - abort has priority over start and load in the same cycle.
- Next and Done are never high in the same cycle.

## Timing
- Reset values: input_data = 0, Next = 0, Done = 0, busy = 0, count = 0, load_ready = 1, state IDLE.
- start sampled at cycle t: first Next at t+1; busy high from t+1.
- Next strobes are exactly GAP+1 cycles apart.
- With N symbols: Done at t+1+N·(GAP+1). For N = 0: Done at t+1.
- compute_done sampled high at cycle c in WAIT: busy = 0 and load_ready = 1 at c+1.
- compute_done is ignored outside WAIT. A level held from a previous run does not shorten WAIT, because WAIT is entered only after FINISH.
- Reset mid-transmission: outputs take reset values asynchronously; no further Next/Done.
- All outputs are registered except load_ready, which is decoded from state and count.

## Structure
- Shared package tm_pkg:
  - SYM_W default constant.
  - typedef enum logic [2:0] feeder_state_t {IDLE, SEND, GAP, FINISH, WAIT}.
  - typedef logic [SYM_W-1:0] symbol_t.
- Sub-module tape_buffer:
  - DEPTH×SYM_W register file.
  - Write port (index, data, enable) and combinational read port.
  - Cleared on reset.
- FSM, gap counter, and rd_ptr live in tape_feeder.

## Test plan
- GAP=4: load 3,5,A; start at cycle 10 → Next at 11,16,21 with input_data 3,5,A; Done at 26; compute_done at 30 → busy = 0 at 31, count = 0.
- Load DEPTH+1 = 9 symbols 0..8 → count = 8, load_ready = 0 after the 8th; symbol 8 is dropped; transmission sends 0..7.
- Empty buffer, start at cycle 5 → no Next; Done at 6; WAIT until compute_done.
- load_valid = 1 (sym 7) with start at the same cycle on 2 buffered symbols (1,2) → three strobes with data 1,2,7.
- abort during GAP after the first of 3 symbols → no further Next, no Done, IDLE and count = 0 next cycle; start while busy ignored.
- Assert reset asynchronously between strobes → Next/Done/busy = 0 immediately; count = 0; a fresh load/start works normally.
